ser_stream_tx: RTL

//  Parametrised successor to the fixed 16-bit serializer.
//  - Converts a DATA_W-bit parallel word into a 1-bit stream with a per-word valid length.
//  - Supports per-word MSB-first or LSB-first order.
//  - A one-word pending buffer allows back-to-back words with no idle cycle.
//  - Sits between a parallel producer (ready/valid) and a bit-serial sink.

---
 rtl/ser_stream_pkg.sv | 13 +
 rtl/ser_shift_core.sv | 50 +++++
 rtl/ser_stream_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/ser_stream_pkg.sv
// Shared types and helpers for the parametrised bit-serial stream transmitter.
package ser_stream_pkg;

  localparam int unsigned DefaultDataW = 16;

  typedef enum logic {StIdle, StShift} state_e;

  // A zero length field encodes a full-width word.
  function automatic int unsigned len_decode(input int unsigned mod, input int unsigned data_w);
    return (mod == 0) ? data_w : mod;
  endfunction

endpackage

// File: rtl/ser_shift_core.sv
// Shift register plus down counter; emits one bit per cycle, MSB- or LSB-first.
module ser_shift_core
  import ser_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [MOD_W-1:0]  len_mod_i,
  input  logic              msb_first_i,
  output logic              bit_o,
  output logic              valid_o,
  output logic              last_o
);

  state_e              state_q;
  logic [DATA_W-1:0]   sreg_q;
  logic [MOD_W-1:0]    cnt_q;
  logic                msb_q;

  // len_mod of 0 (full width) wraps to DATA_W-1, which is the right start count.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
    end else if (load_i) begin
      state_q <= StShift;
      sreg_q  <= word_i;
      cnt_q   <= len_mod_i - MOD_W'(1);
      msb_q   <= msb_first_i;
    end else if (state_q == StShift) begin
      if (cnt_q == '0) begin
        state_q <= StIdle;
      end else begin
        cnt_q  <= cnt_q - MOD_W'(1);
        sreg_q <= msb_q ? {sreg_q[DATA_W-2:0], 1'b0} : {1'b0, sreg_q[DATA_W-1:1]};
      end
    end
  end

  assign valid_o = (state_q == StShift);
  assign last_o  = valid_o && (cnt_q == '0);
  assign bit_o   = valid_o && (msb_q ? sreg_q[DATA_W-1] : sreg_q[0]);

endmodule

// File: rtl/ser_stream_tx.sv
// Ready/valid word input to bit-serial output with a one-word pending buffer and short-word drop.
module ser_stream_tx
  import ser_stream_pkg::*;
#(
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned MIN_LEN = 3,
  parameter int unsigned MOD_W   = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              msb_first_i,
  input  logic              data_val_i,
  output logic              ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o,
  output logic              drop_o
);

  logic [DATA_W-1:0] pend_word_q;
  logic [MOD_W-1:0]  pend_mod_q;
  logic              pend_msb_q;
  logic              pend_full_q, pend_full_d;
  logic              busy_q, busy_d;
  logic              drop_q;

  logic              core_bit, core_valid, core_last;
  logic              core_load;
  logic [DATA_W-1:0] core_word;
  logic [MOD_W-1:0]  core_mod;
  logic              core_msb;

  logic              accept, too_short, core_free;
  logic              pend_load, pend_clear;
  int unsigned       in_len;

  always_comb begin
    in_len     = len_decode(32'(data_mod_i), DATA_W);
    accept     = data_val_i && !pend_full_q;
    too_short  = in_len < MIN_LEN;
    core_free  = !core_valid || core_last;
    core_load  = 1'b0;
    core_word  = data_i;
    core_mod   = data_mod_i;
    core_msb   = msb_first_i;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    if (pend_full_q && core_last) begin
      core_load  = 1'b1;
      core_word  = pend_word_q;
      core_mod   = pend_mod_q;
      core_msb   = pend_msb_q;
      pend_clear = 1'b1;
    end else if (accept && !too_short) begin
      if (core_free) begin
        core_load = 1'b1;
      end else begin
        pend_load = 1'b1;
      end
    end
    pend_full_d = pend_load || (pend_full_q && !pend_clear);
    busy_d      = core_load || (core_valid && !core_last) || pend_full_d;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      pend_word_q <= '0;
      pend_mod_q  <= '0;
      pend_msb_q  <= 1'b0;
      pend_full_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      if (pend_load) begin
        pend_word_q <= data_i;
        pend_mod_q  <= data_mod_i;
        pend_msb_q  <= msb_first_i;
      end
      pend_full_q <= pend_full_d;
      busy_q      <= busy_d;
      drop_q      <= accept && too_short;
    end
  end

  ser_shift_core #(
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W)
  ) u_core (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .load_i      (core_load),
    .word_i      (core_word),
    .len_mod_i   (core_mod),
    .msb_first_i (core_msb),
    .bit_o       (core_bit),
    .valid_o     (core_valid),
    .last_o      (core_last)
  );

  assign ready_o        = !pend_full_q;
  assign ser_data_o     = core_bit;
  assign ser_data_val_o = core_valid;
  assign busy_o         = busy_q;
  assign drop_o         = drop_q;

endmodule
